ob_mk_qry_init: RTL

Query initiator for the market-table quantity query interface. Accepts one client request at a time and issues `qry_vld` pulses to the bid and/or ask table. Waits for each selected table's registered response, then returns per-side quantities and a saturating sum as one response pulse. A per-query timeout guarantees forward progress. Sits between the order-book control/reporting logic and the two market tables.

---
 rtl/ob_pkg.sv | 5 +
 rtl/ob_mk_qry_init_if.sv | 32 +++
 rtl/ob_mk_qry_init.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ob_pkg.sv
// Shared order-book types used by the market-table query path.
package ob_pkg;
    localparam int unsigned ACCUM_QTY_W = 16;
    typedef logic [ACCUM_QTY_W-1:0] accum_quantity_t;
endpackage

// File: rtl/ob_mk_qry_init_if.sv
// Client request/response and bid/ask table query signals of the query initiator.
interface ob_mk_qry_init_if;
    logic                      req_vld;
    logic                      req_rdy;
    logic [1:0]                req_sel;
    logic                      rsp_vld;
    ob_pkg::accum_quantity_t   rsp_bid_qty;
    ob_pkg::accum_quantity_t   rsp_ask_qty;
    ob_pkg::accum_quantity_t   rsp_sum_qty;
    logic                      rsp_err;
    logic [1:0]                rsp_err_sel;
    logic                      bid_qry_vld;
    logic                      bid_qry_rsp_vld_r;
    ob_pkg::accum_quantity_t   bid_qry_rsp_qty_r;
    logic                      ask_qry_vld;
    logic                      ask_qry_rsp_vld_r;
    ob_pkg::accum_quantity_t   ask_qry_rsp_qty_r;

    // master is the initiator; slave is the client plus the two tables
    modport master (
        input  req_vld, req_sel,
        input  bid_qry_rsp_vld_r, bid_qry_rsp_qty_r, ask_qry_rsp_vld_r, ask_qry_rsp_qty_r,
        output req_rdy, rsp_vld, rsp_bid_qty, rsp_ask_qty, rsp_sum_qty, rsp_err, rsp_err_sel,
        output bid_qry_vld, ask_qry_vld
    );
    modport slave (
        output req_vld, req_sel,
        output bid_qry_rsp_vld_r, bid_qry_rsp_qty_r, ask_qry_rsp_vld_r, ask_qry_rsp_qty_r,
        input  req_rdy, rsp_vld, rsp_bid_qty, rsp_ask_qty, rsp_sum_qty, rsp_err, rsp_err_sel,
        input  bid_qry_vld, ask_qry_vld
    );
endinterface

// File: rtl/ob_mk_qry_init.sv
// Market-table quantity query initiator: one outstanding query to bid and/or ask
// table, per-query timeout, single-cycle response with saturating sum.
module ob_mk_qry_init #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    ob_mk_qry_init_if.master   bus
);
    localparam int unsigned CNT_W = 10;
    localparam int unsigned QW    = ob_pkg::ACCUM_QTY_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]              state_r, state_nxt;
    logic [1:0]              sel_r, sel_nxt;
    logic [1:0]              done_r, done_nxt;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt;
    ob_pkg::accum_quantity_t bid_cap_r, bid_cap_nxt;
    ob_pkg::accum_quantity_t ask_cap_r, ask_cap_nxt;

    logic                    req_rdy_nxt;
    logic                    bid_qry_nxt, ask_qry_nxt;
    logic                    rsp_load;
    logic                    rsp_err_nxt;
    logic [1:0]              rsp_err_sel_nxt;
    ob_pkg::accum_quantity_t rsp_bid_nxt, rsp_ask_nxt, rsp_sum_nxt;
    logic [1:0]              newly_done, all_done;
    logic [QW:0]             sum_w;

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state_r;
        sel_nxt         = sel_r;
        done_nxt        = done_r;
        cnt_nxt         = cnt_r;
        bid_cap_nxt     = bid_cap_r;
        ask_cap_nxt     = ask_cap_r;
        bid_qry_nxt     = 1'b0;
        ask_qry_nxt     = 1'b0;
        rsp_load        = 1'b0;
        rsp_err_nxt     = 1'b0;
        rsp_err_sel_nxt = 2'b00;
        rsp_bid_nxt     = '0;
        rsp_ask_nxt     = '0;
        newly_done      = sel_r & ~done_r & {bus.ask_qry_rsp_vld_r, bus.bid_qry_rsp_vld_r};
        all_done        = done_r | newly_done;

        case (state_r)
            ST_IDLE: begin
                if (bus.req_vld && bus.req_rdy) begin
                    sel_nxt     = bus.req_sel;
                    bid_qry_nxt = bus.req_sel[0];
                    ask_qry_nxt = bus.req_sel[1];
                    state_nxt   = ST_ISSUE;
                end
            end
            // Responses are ignored here: a table still shows the previous query's answer.
            ST_ISSUE: begin
                done_nxt = 2'b00;
                cnt_nxt  = '0;
                if (sel_r != 2'b00) begin
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_RESP;
                    rsp_load  = 1'b1;
                end
            end
            ST_WAIT: begin
                done_nxt = all_done;
                if (newly_done[0]) bid_cap_nxt = bus.bid_qry_rsp_qty_r;
                if (newly_done[1]) ask_cap_nxt = bus.ask_qry_rsp_qty_r;
                rsp_bid_nxt = newly_done[0] ? bus.bid_qry_rsp_qty_r : (done_r[0] ? bid_cap_r : '0);
                rsp_ask_nxt = newly_done[1] ? bus.ask_qry_rsp_qty_r : (done_r[1] ? ask_cap_r : '0);
                if (all_done == sel_r) begin
                    state_nxt = ST_RESP;
                    rsp_load  = 1'b1;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt       = ST_RESP;
                    rsp_load        = 1'b1;
                    rsp_err_nxt     = 1'b1;
                    rsp_err_sel_nxt = sel_r & ~all_done;
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        req_rdy_nxt = (state_nxt == ST_IDLE);
        sum_w       = {1'b0, rsp_bid_nxt} + {1'b0, rsp_ask_nxt};
        rsp_sum_nxt = sum_w[QW] ? '1 : sum_w[QW-1:0];
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            sel_r           <= 2'b00;
            done_r          <= 2'b00;
            cnt_r           <= '0;
            bid_cap_r       <= '0;
            ask_cap_r       <= '0;
            bus.req_rdy     <= 1'b0;
            bus.bid_qry_vld <= 1'b0;
            bus.ask_qry_vld <= 1'b0;
            bus.rsp_vld     <= 1'b0;
            bus.rsp_bid_qty <= '0;
            bus.rsp_ask_qty <= '0;
            bus.rsp_sum_qty <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_err_sel <= 2'b00;
        end else begin
            state_r         <= state_nxt;
            sel_r           <= sel_nxt;
            done_r          <= done_nxt;
            cnt_r           <= cnt_nxt;
            bid_cap_r       <= bid_cap_nxt;
            ask_cap_r       <= ask_cap_nxt;
            bus.req_rdy     <= req_rdy_nxt;
            bus.bid_qry_vld <= bid_qry_nxt;
            bus.ask_qry_vld <= ask_qry_nxt;
            bus.rsp_vld     <= rsp_load;
            if (rsp_load) begin
                bus.rsp_bid_qty <= rsp_bid_nxt;
                bus.rsp_ask_qty <= rsp_ask_nxt;
                bus.rsp_sum_qty <= rsp_sum_nxt;
                bus.rsp_err     <= rsp_err_nxt;
                bus.rsp_err_sel <= rsp_err_sel_nxt;
            end
        end
    end
endmodule
